loopback_smoke_inc_pipe: RTL

RTL increment engine that sits directly downstream of `loopback_smoke_bfm`. The BFM presents `inc` requests as a valid/ready stream; this block buffers them, computes `v+1` with overflow detection, and returns tagged responses in order. It supplies the hardware-side counterpart for loopback smoke testing, plus a flush/drain FSM the testbench uses to quiesce between phases.

---
 rtl/loopback_smoke_pkg.sv | 29 ++
 rtl/loopback_smoke_inc_pipe_if.sv | 31 +++
 rtl/loopback_smoke_fifo.sv | 74 +++++++
 rtl/loopback_smoke_inc_pipe.sv | 127 ++++++++++++
 4 files changed

// File: rtl/loopback_smoke_pkg.sv
// rtl/loopback_smoke_pkg.sv - shared types and constants for the loopback smoke increment pipe
// Contents: inc_state_e (flush/drain FSM states), INC_OVF_VAL, DEF_TAG_W,
// inc_rsp_t (response record), inc_calc() (increment with overflow flag).
package loopback_smoke_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACTIVE = 2'd1,
        DRAIN  = 2'd2
    } inc_state_e;

    // Largest positive 32-bit signed value; incrementing it is the only overflow.
    localparam logic [31:0] INC_OVF_VAL = 32'h7FFF_FFFF;

    localparam int DEF_TAG_W = 4;

    typedef struct packed {
        logic [DEF_TAG_W-1:0] tag;
        logic [31:0]          val;
        logic                 ovf;
    } inc_rsp_t;

    // Returns {ovf, v+1}. 32'hFFFF_FFFF wraps to 0 without flagging overflow,
    // because -1 + 1 = 0 is a valid signed result.
    function automatic logic [32:0] inc_calc(input logic [31:0] v);
        return {(v == INC_OVF_VAL), v + 32'd1};
    endfunction

endpackage

// File: rtl/loopback_smoke_inc_pipe_if.sv
// rtl/loopback_smoke_inc_pipe_if.sv - request/response stream bundle for the increment pipe
// Signals: req_valid/req_ready/req_tag/req_val (request stream),
// rsp_valid/rsp_ready/rsp_tag/rsp_val/rsp_ovf (response stream).
// Modports: master (request producer / response consumer), slave (the pipe).
interface loopback_smoke_inc_pipe_if
    import loopback_smoke_pkg::*;
#(
    parameter int TAG_W = DEF_TAG_W
);
    logic             req_valid;
    logic             req_ready;
    logic [TAG_W-1:0] req_tag;
    logic [31:0]      req_val;

    logic             rsp_valid;
    logic             rsp_ready;
    logic [TAG_W-1:0] rsp_tag;
    logic [31:0]      rsp_val;
    logic             rsp_ovf;

    modport master (
        output req_valid, req_tag, req_val, rsp_ready,
        input  req_ready, rsp_valid, rsp_tag, rsp_val, rsp_ovf
    );

    modport slave (
        input  req_valid, req_tag, req_val, rsp_ready,
        output req_ready, rsp_valid, rsp_tag, rsp_val, rsp_ovf
    );

endinterface

// File: rtl/loopback_smoke_fifo.sv
// rtl/loopback_smoke_fifo.sv - synchronous FIFO holding queued increment responses
// Ports: clock, reset (sync active-high), push/push_data, pop/pop_data (head,
// combinational), full, empty, count. Push when full and pop when empty are ignored.
module loopback_smoke_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 37
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         pop_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int PW = $clog2(DEPTH);
    localparam logic [PW-1:0] PTR_ONE  = PW'(1);
    localparam logic [PW:0]   CNT_ONE  = (PW + 1)'(1);
    localparam logic [PW:0]   CNT_FULL = (PW + 1)'(DEPTH);

    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [PW:0]      count_q, count_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic             do_push;
    logic             do_pop;

    assign full     = (count_q == CNT_FULL);
    assign empty    = (count_q == '0);
    assign count    = count_q;
    assign pop_data = mem_q[rd_ptr_q];

    always_comb begin
        do_push  = push && !full;
        do_pop   = pop && !empty;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        mem_d    = mem_q;
        if (do_push) begin
            mem_d[wr_ptr_q] = push_data;
            wr_ptr_d        = wr_ptr_q + PTR_ONE;
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
        end
        if (do_push && !do_pop) begin
            count_d = count_q + CNT_ONE;
        end else if (!do_push && do_pop) begin
            count_d = count_q - CNT_ONE;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage is never read while empty, so it needs no reset.
    always_ff @(posedge clock) begin
        mem_q <= mem_d;
    end

endmodule

// File: rtl/loopback_smoke_inc_pipe.sv
// rtl/loopback_smoke_inc_pipe.sv - in-order increment engine with flush/drain FSM
// Ports: clock, reset (sync active-high), bus (slave: request/response streams),
// flush (level: drain and block input), flush_done (one-cycle pulse when drained),
// req_count/rsp_count (handshake counters, only with LOOPBACK_SMOKE_INC_PIPE_STATS_EN).
module loopback_smoke_inc_pipe
    import loopback_smoke_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int TAG_W = DEF_TAG_W
) (
    input  logic                            clock,
    input  logic                            reset,
    loopback_smoke_inc_pipe_if.slave        bus,
    input  logic                            flush,
    output logic                            flush_done
`ifdef LOOPBACK_SMOKE_INC_PIPE_STATS_EN
    ,
    output logic [31:0]                     req_count,
    output logic [31:0]                     rsp_count
`endif
);
    localparam int CW    = $clog2(DEPTH) + 1;
    localparam int WIDTH = TAG_W + 33;
    localparam logic [CW-1:0] CNT_ONE = CW'(1);

    inc_state_e       state_q, state_d;
    logic             flush_done_q, flush_done_d;
    logic             fifo_full;
    logic             fifo_empty;
    logic [CW-1:0]    fifo_count;
    logic [WIDTH-1:0] push_data;
    logic [WIDTH-1:0] head;
    logic [32:0]      inc_res;
    logic             req_fire;
    logic             rsp_fire;
    logic             drained_next;

    // Ready depends only on registered state, so a request in the same cycle
    // that flush rises is still accepted, and a full FIFO never bypasses.
    assign bus.req_ready = (state_q == ACTIVE) && !fifo_full;
    assign req_fire      = bus.req_valid && bus.req_ready;
    assign rsp_fire      = bus.rsp_valid && bus.rsp_ready;

    assign inc_res   = inc_calc(bus.req_val);
    assign push_data = {bus.req_tag, inc_res[31:0], inc_res[32]};

    loopback_smoke_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (WIDTH)
    ) u_fifo (
        .clock     (clock),
        .reset     (reset),
        .push      (req_fire),
        .push_data (push_data),
        .pop       (rsp_fire),
        .pop_data  (head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    // Head fields are forced to zero while empty so stale storage never shows.
    assign bus.rsp_valid = !fifo_empty;
    assign bus.rsp_tag   = fifo_empty ? '0 : head[WIDTH-1 -: TAG_W];
    assign bus.rsp_val   = fifo_empty ? '0 : head[32:1];
    assign bus.rsp_ovf   = fifo_empty ? 1'b0 : head[0];

    // No pushes happen in DRAIN, so the FIFO is empty after this edge when it
    // already is, or when its last entry is popping now.
    assign drained_next = (fifo_count == '0) || ((fifo_count == CNT_ONE) && rsp_fire);

    always_comb begin
        state_d      = state_q;
        flush_done_d = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (!flush) state_d = ACTIVE;
            end
            ACTIVE: begin
                if (flush) state_d = DRAIN;
            end
            DRAIN: begin
                if (drained_next) begin
                    flush_done_d = 1'b1;
                    state_d      = flush ? IDLE : ACTIVE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= IDLE;
            flush_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            flush_done_q <= flush_done_d;
        end
    end

    assign flush_done = flush_done_q;

`ifdef LOOPBACK_SMOKE_INC_PIPE_STATS_EN
    logic [31:0] req_count_q, req_count_d;
    logic [31:0] rsp_count_q, rsp_count_d;

    always_comb begin
        req_count_d = req_count_q + {31'd0, req_fire};
        rsp_count_d = rsp_count_q + {31'd0, rsp_fire};
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            req_count_q <= '0;
            rsp_count_q <= '0;
        end else begin
            req_count_q <= req_count_d;
            rsp_count_q <= rsp_count_d;
        end
    end

    assign req_count = req_count_q;
    assign rsp_count = rsp_count_q;
`endif

endmodule
